// File: rtl/pedido_pedestre_if.sv
// Pedestrian request interface: button/ack in, request/status out.
// master drives the button side, slave is the request block.
interface pedido_pedestre_if;
  logic       btn_raw;
  logic       ack;
  logic       req;
  logic       busy;
  logic [3:0] served;

  modport master (
    output btn_raw,
    output ack,
    input  req,
    input  busy,
    input  served
  );

  modport slave (
    input  btn_raw,
    input  ack,
    output req,
    output busy,
    output served
  );
endinterface

// File: rtl/pedido_pedestre.sv
// Pedestrian button request: synchronizer, debouncer, and
// IDLE/PEND/COOL request FSM with served counter.
module pedido_pedestre #(
  parameter int DEB_CYCLES = 4,
  parameter int GAP        = 8
) (
  input  logic               clk,
  input  logic               rst,
  pedido_pedestre_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    COOL
  } state_t;

  localparam logic [3:0] DCNT_LAST = 4'(DEB_CYCLES - 1);
  localparam logic [7:0] GAP_V     = 8'(GAP);

  logic       s1_q;
  logic       s2_q;
  logic       deb_q;
  logic       deb_d;
  logic       deb_prev_q;
  logic [3:0] dcnt_q;
  logic [3:0] dcnt_d;
  logic       press;

  state_t     state_q;
  logic [7:0] cool_q;
  logic       req_q;
  logic       busy_q;
  logic [3:0] served_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= bus.btn_raw;
      s2_q <= s1_q;
    end
  end

  // deb flips on the edge where the mismatch run would hit DEB_CYCLES
  always_comb begin
    dcnt_d = '0;
    deb_d  = deb_q;
    if (s2_q != deb_q) begin
      if (dcnt_q == DCNT_LAST) begin
        deb_d = s2_q;
      end else begin
        dcnt_d = dcnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      dcnt_q     <= '0;
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      dcnt_q     <= dcnt_d;
    end
  end

  assign press = deb_q & ~deb_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cool_q   <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      served_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (press) begin
            state_q <= PEND;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        PEND: begin
          // ack wins over a coincident press
          if (bus.ack) begin
            served_q <= served_q + 4'd1;
            req_q    <= 1'b0;
            if (GAP == 0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= COOL;
              cool_q  <= GAP_V;
            end
          end
        end
        COOL: begin
          if (cool_q == 8'd1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cool_q  <= '0;
          end else begin
            cool_q <= cool_q - 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          cool_q  <= '0;
        end
      endcase
    end
  end

  assign bus.req    = req_q;
  assign bus.busy   = busy_q;
  assign bus.served = served_q;

endmodule

// File: tb/tb_pedido_pedestre.sv
// Self-checking bench for pedido_pedestre: vector table,
// directed corner sequences and random run vs reference model.
module tb_pedido_pedestre;

  localparam int D   = 4;
  localparam int GAP = 8;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  pedido_pedestre_if bus ();

  pedido_pedestre #(
    .DEB_CYCLES(D),
    .GAP       (GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       btn;
    logic       ack;
    logic       req;
    logic       busy;
    logic [3:0] served;
  } vec_t;

  vec_t vt[18];

  // reference model state
  logic m_deb;
  logic m_deb_prev;
  logic m_pend;
  int   m_cool;
  int   m_served;
  logic bq[$];
  logic s2q[$];

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_deb      = 1'b0;
    m_deb_prev = 1'b0;
    m_pend     = 1'b0;
    m_cool     = 0;
    m_served   = 0;
    bq.delete();
    s2q.delete();
  endtask

  // s2 at edge n is the button sampled at edge n-2; deb
  // flips once D consecutive s2 samples disagree with it
  task automatic model_step(input logic b, input logic a);
    logic s2p;
    logic press;
    logic flip;
    s2p = (bq.size() >= 2) ? bq[bq.size()-2] : 1'b0;
    press = m_deb && !m_deb_prev;
    if (m_pend) begin
      if (a) begin
        m_pend   = 1'b0;
        m_served = (m_served + 1) % 16;
        m_cool   = GAP;
      end
    end else if (m_cool > 0) begin
      m_cool = m_cool - 1;
    end else if (press) begin
      m_pend = 1'b1;
    end
    s2q.push_back(s2p);
    flip = (s2q.size() >= D);
    for (int i = 0; i < D; i++)
      if (flip && s2q[s2q.size()-1-i] == m_deb)
        flip = 1'b0;
    m_deb_prev = m_deb;
    if (flip) m_deb = !m_deb;
    bq.push_back(b);
    while (bq.size() > 16) void'(bq.pop_front());
    while (s2q.size() > 16) void'(s2q.pop_front());
  endtask

  // called at the #1-after-edge phase
  task automatic cyc(input logic b, input logic a);
    bus.btn_raw = b;
    bus.ack     = a;
    model_step(b, a);
    @(posedge clk);
    #1;
    chk("model_req", int'(bus.req), int'(m_pend));
    chk("model_busy", int'(bus.busy),
        int'(m_pend || m_cool > 0));
    chk("model_served", int'(bus.served), m_served);
  endtask

  task automatic do_reset();
    bus.btn_raw = 1'b0;
    bus.ack     = 1'b0;
    rst = 1'b1;
    model_reset();
    #2;
    chk("rst_req", int'(bus.req), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_served", int'(bus.served), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  initial begin
    int   lvl;
    int   run;
    logic a;
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    bus.btn_raw = 1'b0;
    bus.ack     = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // clean press then serve, edge i = table index
    for (int i = 0; i < 18; i++) begin
      vt[i].btn    = (i < 10);
      vt[i].ack    = (i == 8);
      vt[i].req    = (i >= 6 && i < 8);
      vt[i].busy   = (i >= 6 && i <= 15);
      vt[i].served = (i >= 8) ? 4'd1 : 4'd0;
    end
    do_reset();
    for (int i = 0; i < 18; i++) begin
      cyc(vt[i].btn, vt[i].ack);
      chk($sformatf("vec%0d_req", i), int'(bus.req),
          int'(vt[i].req));
      chk($sformatf("vec%0d_busy", i), int'(bus.busy),
          int'(vt[i].busy));
      chk($sformatf("vec%0d_served", i), int'(bus.served),
          int'(vt[i].served));
    end

    // bouncing button never qualifies
    do_reset();
    for (int i = 0; i < 30; i++) begin
      cyc((i < 20) && ((i / 2) % 2 == 0), 1'b0);
      chk("bounce_req", int'(bus.req), 0);
      chk("bounce_served", int'(bus.served), 0);
    end

    // merge, ack, press landing inside cooldown
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0);
    chk("merge_req1", int'(bus.req), 1);
    idle_n(8);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0);
    idle_n(8);
    chk("merge_still_pend", int'(bus.req), 1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    chk("merge_served", int'(bus.served), 1);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b0);
      chk("cool_press_req", int'(bus.req), 0);
    end
    chk("cool_busy_end", int'(bus.busy), 0);
    chk("cool_served", int'(bus.served), 1);
    idle_n(8);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0);
    chk("new_press_req", int'(bus.req), 1);

    // 16 serves wrap the counter
    do_reset();
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      chk("wrap_served", int'(bus.served), (n + 1) % 16);
      idle_n(10);
    end
    chk("wrap_zero", int'(bus.served), 0);

    // press event and ack on the same edge
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0);
    idle_n(6);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    chk("coll_req", int'(bus.req), 0);
    chk("coll_busy", int'(bus.busy), 1);
    chk("coll_served", int'(bus.served), 1);
    idle_n(12);

    // async reset mid-PEND with the button held
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    idle_n(10);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0);
    chk("ar_pend", int'(bus.req), 1);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("ar_req", int'(bus.req), 0);
    chk("ar_busy", int'(bus.busy), 0);
    chk("ar_served", int'(bus.served), 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int i = 0; i < D + 3; i++) begin
      cyc(1'b1, 1'b0);
      if (i == D + 1) chk("ar_req_lo", int'(bus.req), 0);
      if (i == D + 2) chk("ar_req_hi", int'(bus.req), 1);
    end

    // random button runs and acks vs reference model
    do_reset();
    lvl = 0;
    run = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        lvl = 1 - lvl;
        run = $urandom_range(1, 10);
      end
      run--;
      a = ($urandom % 5 == 0);
      cyc(lvl[0], a);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
